ps2_piano_keys: RTL
===================

Name: ps2_piano_keys

Overview:
- Upstream input stage of the piano player: receives raw PS/2 keyboard frames and produces the 48-bit one-hot-per-key `keys` vector consumed by the player control block.
- 12 physical note keys cover one octave; 4 octave-select keys shift that row across the 48-key range (4 octaves × 12 notes).
- Make/break decoding keeps every note bit asserted for as long as its physical key is held.

Parameters:
- SYNC_STAGES, 2, flip-flop stages synchronising ps2_clk and ps2_data into clk.
- TIMEOUT_CYC, 50000, clk cycles with no ps2_clk falling edge before a partial frame is discarded.
- OCTAVE_RESET, 1, octave value after reset (0..3).

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock line (asynchronous).
- ps2_data  input  1  raw PS/2 data line (asynchronous).
- keys  output  48  bit i high = key i held; i = octave*12 + note.
- octave  output  2  current octave selection.
- scan_code  output  8  last correctly received byte.
- code_valid  output  1  one-cycle pulse when scan_code updates.
- frame_err  output  1  one-cycle pulse on a framing, parity or timeout error.

Behaviour:
- Reset values:
  - keys = 0, scan_code = 0, code_valid = 0, frame_err = 0.
  - octave = OCTAVE_RESET.
  - Receiver and decoder FSMs return to IDLE; partial frame and prefix flags are cleared.
  - Reset mid-frame discards the frame.
- Synchroniser: ps2_clk and ps2_data each pass through SYNC_STAGES flops. A falling edge is detected as prev = 1, cur = 0 on the synchronised clock.
- Receiver: 11-bit frame, one bit sampled per falling edge, in this order:
  - start bit (must be 0),
  - 8 data bits, LSB first,
  - odd parity bit,
  - stop bit (must be 1).
- Bit counter 0..10:
  - Resets to 0 after the stop bit.
  - Resets to 0 on timeout: counter ≠ 0 and idle counter reaches TIMEOUT_CYC. Timeout also pulses frame_err.
- Frame completion:
  - Good frame: on the clk cycle after the stop-bit sample, scan_code <= data and code_valid = 1 for exactly 1 cycle.
  - Start = 1, stop = 0, or parity error: no code_valid, frame_err = 1 for 1 cycle, decoder prefix flags cleared.
- Decoder FSM, advanced only on code_valid. States: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
  - IDLE: F0 -> BRK; E0 -> EXT; other code -> make(code), stay IDLE.
  - BRK: code -> break(code), go to IDLE.
  - EXT: F0 -> EXT_BRK; other code ignored, go to IDLE.
  - EXT_BRK: code ignored, go to IDLE.
- Note map, note index 0..11 = Z 1A, S 1B, X 22, D 23, C 21, V 2A, G 34, B 32, H 33, N 31, J 3B, M 3A.
- Octave map: '1' 16 -> 0, '2' 1E -> 1, '3' 26 -> 2, '4' 25 -> 3.
- make(note) sets held[note]; break(note) clears held[note].
- Make of an octave key sets octave; break of an octave key has no effect.
- Unmapped codes: no effect. Repeated make (typematic) of a held note: no change.
- keys is registered: keys = {36'b0, held[11:0]} << (octave*12).
  - Updates in the same cycle code_valid is high, so latency from stop-bit sample to keys change is 1 clk.
  - Changing octave while notes are held moves those bits to the new octave, without clearing them.
- Multiple held notes produce multiple bits in keys; priority among them is the consumer's job.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: the odd-parity check is active; a parity mismatch drops the byte and pulses frame_err as above.
- Undefined: the parity bit is sampled but ignored. Only start and stop violations or timeout cause frame_err.

Test Plan:
- Reset, then send frame 1A (parity 0) -> code_valid pulse, scan_code = 1A, keys = 1 << 12 (octave 1, note 0).
- Send 1A, 1B, then F0 1A -> keys goes 0x1000 -> 0x3000 -> 0x2000; after the F0 byte keys is unchanged and the FSM is in BRK.
- Hold 3A (note 11), send 25 -> octave = 3, keys = 1 << 47; then send 16 -> octave = 0, keys = 1 << 11.
- Send E0 1A, then E0 F0 1A -> keys stays 0; FSM returns to IDLE after each sequence.
- Frame with wrong parity (PS2_PARITY_CHECK_EN defined) -> frame_err for 1 cycle, no code_valid, keys unchanged. Repeat with the macro undefined -> code_valid, and keys updated.
- Stop ps2_clk after 5 bits for TIMEOUT_CYC cycles -> frame_err pulse. The next full frame 22 is received correctly -> keys bit 14 set.

Source files
------------

// File: rtl/ps2_piano_keys.sv
`default_nettype none
// ============================================================================
// ps2_piano_keys : PS/2 frame receiver and make/break decoder that produces
//                  the 48-key held vector (4 octaves x 12 notes).
// Optional feature macro: PS2_PARITY_CHECK_EN (enables the odd-parity check).
// Revision: 1.0
// ============================================================================
module ps2_piano_keys #(
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT_CYC  = 50000,
  parameter int OCTAVE_RESET = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [47:0] keys,
  output logic [1:0]  octave,
  output logic [7:0]  scan_code,
  output logic        code_valid,
  output logic        frame_err
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] c_timeout = IDLE_W'(TIMEOUT_CYC);
  localparam logic [7:0] c_break = 8'hF0;
  localparam logic [7:0] c_ext   = 8'hE0;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   bit_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign bit_in = data_sync[SYNC_STAGES-1];

  logic [3:0]        bit_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [7:0]        data_sr;
  logic              start_bit;
  logic              parity_ok;
  logic              stop_edge;
  logic              timeout;
  logic              code_ok;
  logic              frame_bad;

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  assign parity_ok = ^{data_sr, par_bit};
`else
  assign parity_ok = 1'b1;
`endif

  assign stop_edge = fall && (bit_cnt == 4'd10);
  assign code_ok   = stop_edge && !start_bit && bit_in && parity_ok;
  assign timeout   = !fall && (bit_cnt != 4'd0) && (idle_cnt == c_timeout);
  assign frame_bad = (stop_edge && !code_ok) || timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= 4'd0;
      idle_cnt   <= '0;
      data_sr    <= 8'd0;
      start_bit  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit    <= 1'b0;
`endif
      scan_code  <= 8'd0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= code_ok;
      frame_err  <= frame_bad;
      if (code_ok) scan_code <= data_sr;
      if (fall) begin
        idle_cnt <= '0;
        case (bit_cnt)
          4'd0:    start_bit <= bit_in;
`ifdef PS2_PARITY_CHECK_EN
          4'd9:    par_bit   <= bit_in;
`else
          4'd9:    ;
`endif
          4'd10:   ;
          default: data_sr   <= {bit_in, data_sr[7:1]};
        endcase
        bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
      end else if (timeout) begin
        bit_cnt  <= 4'd0;
        idle_cnt <= '0;
      end else if (bit_cnt != 4'd0) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  // {hit, index} lookups for the note row and the octave-select keys
  function automatic logic [4:0] note_of(input logic [7:0] c);
    case (c)
      8'h1A:   note_of = {1'b1, 4'd0};
      8'h1B:   note_of = {1'b1, 4'd1};
      8'h22:   note_of = {1'b1, 4'd2};
      8'h23:   note_of = {1'b1, 4'd3};
      8'h21:   note_of = {1'b1, 4'd4};
      8'h2A:   note_of = {1'b1, 4'd5};
      8'h34:   note_of = {1'b1, 4'd6};
      8'h32:   note_of = {1'b1, 4'd7};
      8'h33:   note_of = {1'b1, 4'd8};
      8'h31:   note_of = {1'b1, 4'd9};
      8'h3B:   note_of = {1'b1, 4'd10};
      8'h3A:   note_of = {1'b1, 4'd11};
      default: note_of = 5'd0;
    endcase
  endfunction

  function automatic logic [2:0] oct_of(input logic [7:0] c);
    case (c)
      8'h16:   oct_of = {1'b1, 2'd0};
      8'h1E:   oct_of = {1'b1, 2'd1};
      8'h26:   oct_of = {1'b1, 2'd2};
      8'h25:   oct_of = {1'b1, 2'd3};
      default: oct_of = 3'd0;
    endcase
  endfunction

  function automatic logic [47:0] place(input logic [11:0] h, input logic [1:0] o);
    case (o)
      2'd0:    place = {36'd0, h};
      2'd1:    place = {24'd0, h, 12'd0};
      2'd2:    place = {12'd0, h, 24'd0};
      default: place = {h, 36'd0};
    endcase
  endfunction

  typedef enum logic [1:0] {DEC_IDLE, DEC_BRK, DEC_EXT, DEC_EXT_BRK} dec_state_t;

  dec_state_t  dec_state;
  logic [11:0] held;
  logic [11:0] held_next;
  logic [1:0]  oct_next;
  logic [4:0]  note_hit;
  logic [2:0]  oct_hit;
  logic        is_prefix;
  logic        do_make;
  logic        do_break;

  assign note_hit  = note_of(data_sr);
  assign oct_hit   = oct_of(data_sr);
  assign is_prefix = (data_sr == c_break) || (data_sr == c_ext);
  assign do_make   = code_ok && (dec_state == DEC_IDLE) && !is_prefix;
  assign do_break  = code_ok && (dec_state == DEC_BRK);

  assign held_next = (do_make && note_hit[4])  ? (held |  (12'd1 << note_hit[3:0])) :
                     (do_break && note_hit[4]) ? (held & ~(12'd1 << note_hit[3:0])) :
                     held;
  assign oct_next  = (do_make && oct_hit[2]) ? oct_hit[1:0] : octave;

  // keys tracks the next held/octave so it moves on the same edge as code_valid
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_state <= DEC_IDLE;
      held      <= 12'd0;
      octave    <= 2'(OCTAVE_RESET);
      keys      <= 48'd0;
    end else begin
      held   <= held_next;
      octave <= oct_next;
      keys   <= place(held_next, oct_next);
      if (frame_bad) begin
        dec_state <= DEC_IDLE;
      end else if (code_ok) begin
        case (dec_state)
          DEC_IDLE: begin
            if (data_sr == c_break)    dec_state <= DEC_BRK;
            else if (data_sr == c_ext) dec_state <= DEC_EXT;
            else                       dec_state <= DEC_IDLE;
          end
          DEC_BRK: dec_state <= DEC_IDLE;
          DEC_EXT: dec_state <= (data_sr == c_break) ? DEC_EXT_BRK : DEC_IDLE;
          default: dec_state <= DEC_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
